// File: rtl/pairing_bridge_pkg.sv
// Shared constants and state encoding for the tate_pairing host-side bridge.
package pairing_bridge_pkg;

  localparam int unsigned M           = 97;
  localparam int unsigned W           = 32;
  localparam int unsigned OP_W        = 2 * M;
  localparam int unsigned RES_W       = 12 * M;
  localparam int unsigned IN_WPO      = (OP_W + W - 1) / W;
  localparam int unsigned IN_WORDS    = 4 * IN_WPO;
  localparam int unsigned OUT_WORDS   = (RES_W + W - 1) / W;
  localparam int unsigned KICK_CYCLES = 2;

  localparam int unsigned KICK_W = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;
  localparam int unsigned WD_W   = $clog2(IN_WPO);
  localparam int unsigned OCNT_W = $clog2(OUT_WORDS);
  localparam int unsigned IDX_W  = $clog2(IN_WPO * W);

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StKick  = 2'd1,
    StRun   = 2'd2,
    StDrain = 2'd3
  } state_e;

endpackage

// File: rtl/pairing_io_bridge_if.sv
// Host-facing word streams: operand words in, result words out.
interface pairing_io_bridge_if;
  import pairing_bridge_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/result_serializer.sv
// Parallel-loads the pairing result and shifts it out W bits per accepted beat.
module result_serializer
  import pairing_bridge_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [RES_W-1:0] data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     out_data_o,
  output logic             out_last_o
);

  logic [OUT_WORDS*W-1:0] sreg_q, sreg_d;
  logic [OCNT_W-1:0]      ocnt_q, ocnt_d;
  logic                   valid_q, valid_d;
  logic                   last;

  assign last        = valid_q && (ocnt_q == OCNT_W'(OUT_WORDS - 1));
  assign out_valid_o = valid_q;
  assign out_data_o  = sreg_q[W-1:0];
  assign out_last_o  = last;

  always_comb begin
    sreg_d  = sreg_q;
    ocnt_d  = ocnt_q;
    valid_d = valid_q;
    if (load_i) begin
      // Zero-extend so the final partial word carries zeros above the result.
      sreg_d              = '0;
      sreg_d[RES_W-1:0]   = data_i;
      ocnt_d              = '0;
      valid_d             = 1'b1;
    end else if (valid_q && out_ready_i) begin
      sreg_d = sreg_q >> W;
      if (last) begin
        ocnt_d  = '0;
        valid_d = 1'b0;
      end else begin
        ocnt_d = ocnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q  <= '0;
      ocnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      ocnt_q  <= ocnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/pairing_io_bridge.sv
// Loads four operands into tate_pairing, runs it under a reset-start/done
// handshake and streams the captured result back to the host.
module pairing_io_bridge
  import pairing_bridge_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  pairing_io_bridge_if.slave  host,
  output logic                busy,
  output logic                core_reset,
  output logic [OP_W-1:0]     core_x1,
  output logic [OP_W-1:0]     core_y1,
  output logic [OP_W-1:0]     core_x2,
  output logic [OP_W-1:0]     core_y2,
  input  logic                core_done,
  input  logic [RES_W-1:0]    core_out
);

  state_e                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic [KICK_W-1:0]       kick_q, kick_d;
  logic                    in_ready_q, in_ready_d;
  logic                    core_reset_q, core_reset_d;
  logic [3:0][OP_W-1:0]    ops_q, ops_d;
  logic [IN_WPO*W-1:0]     wide;
  logic [IDX_W-1:0]        base;
  logic                    in_fire, drain_done, load_res;

  assign in_fire    = host.in_valid & in_ready_q;
  assign drain_done = host.out_valid & host.out_ready & host.out_last;
  assign base       = IDX_W'(wd_q * W);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wd_d     = wd_q;
    kick_d   = kick_q;
    ops_d    = ops_q;
    wide     = '0;
    load_res = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (in_fire) begin
          // Build in a full word-aligned view; bits past 2*M fall away on write-back.
          wide[OP_W-1:0]  = ops_q[op_q];
          wide[base +: W] = host.in_data;
          ops_d[op_q]     = wide[OP_W-1:0];
          if (wd_q == WD_W'(IN_WPO - 1)) begin
            wd_d = '0;
            op_d = op_q + 2'd1;
            if (op_q == 2'd3) begin
              state_d = StKick;
              kick_d  = '0;
            end
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      StKick: begin
        if (kick_q == KICK_W'(KICK_CYCLES - 1)) begin
          state_d = StRun;
          kick_d  = '0;
        end else begin
          kick_d = kick_q + 1'b1;
        end
      end
      StRun: begin
        if (core_done) begin
          load_res = 1'b1;
          state_d  = StDrain;
        end
      end
      StDrain: begin
        if (drain_done) state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
    in_ready_d   = (state_d == StLoad);
    // Core is held in reset everywhere except while computing and draining.
    core_reset_d = (state_d == StLoad) || (state_d == StKick);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StLoad;
      op_q         <= '0;
      wd_q         <= '0;
      kick_q       <= '0;
      ops_q        <= '0;
      in_ready_q   <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wd_q         <= wd_d;
      kick_q       <= kick_d;
      ops_q        <= ops_d;
      in_ready_q   <= in_ready_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign host.in_ready = in_ready_q;
  assign core_reset    = core_reset_q;
  assign busy          = (state_q != StLoad);
  assign core_x1       = ops_q[0];
  assign core_y1       = ops_q[1];
  assign core_x2       = ops_q[2];
  assign core_y2       = ops_q[3];

  result_serializer u_result_serializer (
    .clk_i       (clk),
    .rst_ni      (reset),
    .load_i      (load_res),
    .data_i      (core_out),
    .out_valid_o (host.out_valid),
    .out_ready_i (host.out_ready),
    .out_data_o  (host.out_data),
    .out_last_o  (host.out_last)
  );

endmodule

// File: tb/tb_pairing_io_bridge.sv
// Scoreboard bench for pairing_io_bridge: loads, completion, backpressure,
// illegal input, stale done and mid-job reset.
module tb_pairing_io_bridge;
  import pairing_bridge_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             busy, core_reset, core_done;
  logic [OP_W-1:0]  core_x1, core_y1, core_x2, core_y2;
  logic [RES_W-1:0] core_out;
  logic [OP_W-1:0]  dut_ops [4];

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  pairing_io_bridge_if host_if ();

  pairing_io_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .host       (host_if),
    .busy       (busy),
    .core_reset (core_reset),
    .core_x1    (core_x1),
    .core_y1    (core_y1),
    .core_x2    (core_x2),
    .core_y2    (core_y2),
    .core_done  (core_done),
    .core_out   (core_out)
  );

  assign dut_ops[0] = core_x1;
  assign dut_ops[1] = core_y1;
  assign dut_ops[2] = core_x2;
  assign dut_ops[3] = core_y2;

  function automatic logic [OP_W-1:0] exp_op(input logic [31:0] b, input int op);
    logic [IN_WPO*W-1:0] w;
    for (int k = 0; k < IN_WPO; k++) w[k*W +: W] = b + 32'(op * IN_WPO + k);
    return w[OP_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d);
    int t = 0;
    host_if.in_valid = 1'b1;
    host_if.in_data  = d;
    while (host_if.in_ready !== 1'b1 && t < 100) begin tick(); t++; end
    if (host_if.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_word timeout: in_ready=%b required 1", host_if.in_ready);
    end
    tick();
    host_if.in_valid = 1'b0;
  endtask

  task automatic load_job(input logic [31:0] b, input bit gaps);
    for (int n = 0; n < IN_WORDS; n++) begin
      send_word(b + 32'(n));
      if (gaps && (n % 3 == 1)) repeat (1 + n % 2) tick();
    end
  endtask

  task automatic wait_run();
    int t = 0;
    while (core_reset !== 1'b0 && t < 50) begin tick(); t++; end
    checks++;
    if (core_reset !== 1'b0) begin
      errors++;
      $display("FAIL wait_run: core_reset=%b required 0", core_reset);
    end
  endtask

  task automatic push_result(input logic [RES_W-1:0] v);
    logic [OUT_WORDS*W-1:0] ext;
    ext = '0;
    ext[RES_W-1:0] = v;
    for (int k = 0; k < OUT_WORDS; k++) sb.push_back(ext[k*W +: W]);
  endtask

  // Pops one scoreboard entry per accepted beat; optional stall window and random ready.
  task automatic drain(input int stall_at, input bit rand_bp, input int stop_at,
                       output int beats);
    int          t = 0, stall_cnt = 0;
    bit          rdy, stalled = 1'b0;
    logic [31:0] held, exp;
    beats = 0;
    while (beats < stop_at && t < 3000) begin
      t++;
      if (stalled) begin
        checks++;
        if ({host_if.out_valid, host_if.out_data} !== {1'b1, held}) begin
          errors++;
          $display("FAIL stall_stable: valid=%b data=%h required 1 %h",
                   host_if.out_valid, host_if.out_data, held);
        end
      end
      if (host_if.out_valid === 1'b1) begin
        if (beats == stall_at && stall_cnt < 10) begin rdy = 1'b0; stall_cnt++; end
        else if (rand_bp) rdy = 1'($urandom_range(0, 1));
        else rdy = 1'b1;
        host_if.out_ready = rdy;
        if (rdy) begin
          exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
          checks++;
          if (host_if.out_data !== exp) begin
            errors++;
            $display("FAIL out_data[%0d]: got %h required %h", beats, host_if.out_data, exp);
          end
          checks++;
          if (host_if.out_last !== (beats == OUT_WORDS - 1)) begin
            errors++;
            $display("FAIL out_last[%0d]: got %b required %b", beats, host_if.out_last,
                     beats == OUT_WORDS - 1);
          end
          beats++;
          stalled = 1'b0;
        end else begin
          held    = host_if.out_data;
          stalled = 1'b1;
        end
      end else begin
        host_if.out_ready = 1'b0;
      end
      tick();
    end
    host_if.out_ready = 1'b0;
    checks++;
    if (beats != stop_at) begin
      errors++;
      $display("FAIL drain_beats: got %0d required %0d", beats, stop_at);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({host_if.in_ready, host_if.out_valid, host_if.out_last, busy, core_reset} !== 5'b00001
        || host_if.out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy/ov/ol/busy/crst=%b%b%b%b%b data=%h required 00001 0",
               host_if.in_ready, host_if.out_valid, host_if.out_last, busy, core_reset,
               host_if.out_data);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_ops[i] !== '0) begin
        errors++;
        $display("FAIL reset_op%0d: got %h required 0", i, dut_ops[i]);
      end
    end
    #3 reset = 1'b1;
    tick();
    checks++;
    if (host_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b required 1", host_if.in_ready);
    end
  endtask

  task automatic test_basic_load();
    load_job(32'h1000_0000, 1'b0);
    checks++;
    if (core_x1[31:0] !== 32'h1000_0000 || core_y2[193:192] !== 2'b11) begin
      errors++;
      $display("FAIL basic_load_words: x1[31:0]=%h y2[193:192]=%b required 10000000 11",
               core_x1[31:0], core_y2[193:192]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_ops[i] !== exp_op(32'h1000_0000, i)) begin
        errors++;
        $display("FAIL basic_op%0d: got %h required %h", i, dut_ops[i],
                 exp_op(32'h1000_0000, i));
      end
    end
    checks++;
    if ({core_reset, busy, host_if.in_ready} !== 3'b110) begin
      errors++;
      $display("FAIL kick_entry: crst/busy/rdy=%b%b%b required 110", core_reset, busy,
               host_if.in_ready);
    end
    tick();
    checks++;
    if (core_reset !== 1'b1) begin
      errors++;
      $display("FAIL kick_hold: core_reset=%b required 1", core_reset);
    end
    tick();
    checks++;
    if (core_reset !== 1'b0) begin
      errors++;
      $display("FAIL run_release: core_reset=%b required 0", core_reset);
    end
  endtask

  task automatic test_completion();
    int beats;
    repeat (4) begin
      tick();
      checks++;
      if (host_if.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL run_idle_valid: got %b required 0", host_if.out_valid);
      end
    end
    core_out  = {RES_W{1'b1}};
    core_done = 1'b1;
    for (int k = 0; k < OUT_WORDS - 1; k++) sb.push_back(32'hFFFF_FFFF);
    sb.push_back(32'h0000_0FFF);
    tick();
    core_out = '0;  // done stays high in DRAIN with a changed result
    drain(-1, 1'b0, OUT_WORDS, beats);
    checks++;
    if ({busy, core_reset, host_if.out_valid, host_if.in_ready} !== 4'b0101) begin
      errors++;
      $display("FAIL post_drain: busy/crst/ov/rdy=%b%b%b%b required 0101", busy, core_reset,
               host_if.out_valid, host_if.in_ready);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty_completion: got %0d required 0", sb.size());
    end
    core_done = 1'b0;
  endtask

  task automatic test_backpressure();
    int               beats;
    logic [RES_W-1:0] v;
    logic [OUT_WORDS*W-1:0] ext;
    load_job(32'h2000_0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_ops[i] !== exp_op(32'h2000_0000, i)) begin
        errors++;
        $display("FAIL gapped_op%0d: got %h required %h", i, dut_ops[i],
                 exp_op(32'h2000_0000, i));
      end
    end
    wait_run();
    host_if.in_valid = 1'b1;
    host_if.in_data  = 32'hDEAD_BEEF;
    repeat (5) begin
      checks++;
      if (host_if.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL run_in_ready: got %b required 0", host_if.in_ready);
      end
      tick();
    end
    host_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_ops[i] !== exp_op(32'h2000_0000, i)) begin
        errors++;
        $display("FAIL illegal_in_op%0d: got %h required %h", i, dut_ops[i],
                 exp_op(32'h2000_0000, i));
      end
    end
    ext = '0;
    for (int k = 0; k < OUT_WORDS; k++) ext[k*W +: W] = 32'hA500_0000 + 32'(k);
    v = ext[RES_W-1:0];
    push_result(v);
    core_out  = v;
    core_done = 1'b1;
    drain(5, 1'b1, OUT_WORDS, beats);
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_end: sb=%0d busy=%b required 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_stale_done();
    int beats;
    // core_done still high from the previous job, with a stale result.
    load_job(32'h3000_0000, 1'b0);
    wait_run();
    core_done = 1'b0;
    checks++;
    if ({busy, host_if.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL stale_kick: busy/ov=%b%b required 10", busy, host_if.out_valid);
    end
    repeat (3) begin
      tick();
      checks++;
      if (host_if.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_run_valid: got %b required 0", host_if.out_valid);
      end
    end
    core_out = {RES_W{1'b0}} | {8'h5A, 120'h0, 32'h1234_5678};
    push_result(core_out);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    drain(-1, 1'b0, OUT_WORDS, beats);
  endtask

  task automatic test_reset_mid_job();
    int beats;
    load_job(32'h4000_0000, 1'b0);
    wait_run();
    core_out = {RES_W{1'b1}} ^ {RES_W/4{4'b1010}};
    push_result(core_out);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    drain(-1, 1'b0, 10, beats);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({host_if.out_valid, busy, core_reset, host_if.in_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL mid_reset: ov/busy/crst/rdy=%b%b%b%b required 0010", host_if.out_valid,
               busy, core_reset, host_if.in_ready);
    end
    checks++;
    if (core_x1 !== '0 || core_y2 !== '0) begin
      errors++;
      $display("FAIL mid_reset_ops: x1=%h y2=%h required 0 0", core_x1, core_y2);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    sb.delete();
    tick();
    load_job(32'h5000_0000, 1'b1);
    checks++;
    if (core_x1[31:0] !== 32'h5000_0000) begin
      errors++;
      $display("FAIL reload_x1_w0: got %h required 50000000", core_x1[31:0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_ops[i] !== exp_op(32'h5000_0000, i)) begin
        errors++;
        $display("FAIL reload_op%0d: got %h required %h", i, dut_ops[i],
                 exp_op(32'h5000_0000, i));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    host_if.in_valid  = 1'b0;
    host_if.in_data   = '0;
    host_if.out_ready = 1'b0;
    core_done         = 1'b0;
    core_out          = '0;
    #1;
    test_reset();
    test_basic_load();
    test_completion();
    test_backpressure();
    test_stale_done();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pairing_io_bridge.md
Name: pairing_io_bridge

Overview:
- Host-side initiator for the tate_pairing core.
- Accepts the four GF(3^97)^2 operands over a narrow valid/ready word stream.
- Holds the core in reset while loading, then releases it and waits for the core's done.
- Captures the 12*M-bit result and streams it back out as words.
- Sits between the system bus adapter and tate_pairing; it drives the far end of the core's reset-start/done protocol.

Parameters:
- M, 97, field extension degree; each operand is 2*M bits and the result is 12*M bits.
- W, 32, stream word width.
- Derived (package constants, not overridable):
  - IN_WPO = ceil(2*M/W) = 7 words per operand.
  - IN_WORDS = 4*IN_WPO = 28.
  - OUT_WORDS = ceil(12*M/W) = 37.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  host word valid.
- in_ready  out  1  bridge accepts a word.
- in_data  in  W  operand word.
- out_valid  out  1  result word valid.
- out_ready  in  1  host accepts a result word.
- out_data  out  W  result word.
- out_last  out  1  marks the final result word.
- busy  out  1  high outside LOAD state.
- core_reset  out  1  active-high synchronous reset/start to tate_pairing.
- core_x1, core_y1, core_x2, core_y2  out  2*M each  operand registers.
- core_done  in  1  tate_pairing done.
- core_out  in  12*M  tate_pairing result.

Behaviour:
- Async reset (reset=0), all outputs:
  - state=LOAD, core_reset=1.
  - in_ready=0 while reset is asserted, 1 from the first clock after release.
  - out_valid=0, out_last=0, out_data=0, busy=0.
  - core_x1..core_y2=0; word counters=0.
- LOAD:
  - in_ready=1 and core_reset=1.
  - Each beat with in_valid&in_ready writes in_data into operand (cnt/IN_WPO), word (cnt%IN_WPO).
  - Word 0 is least significant.
  - Operand order is x1, y1, x2, y2.
  - Word 6 of each operand contributes only bits [1:0] (2*M-6*W=2); its upper W-2 bits are discarded.
  - On the beat with cnt=27 go to KICK; cnt wraps to 0.
- KICK:
  - Lasts 2 cycles; in_ready=0, core_reset=1.
  - core_done is ignored in this state.
  - Then go to RUN.
- RUN:
  - core_reset=0, in_ready=0.
  - The first cycle with core_done=1 copies core_out into a 12*M-bit output shift register, zero-extended to OUT_WORDS*W=1184 bits, and enters DRAIN.
  - There is no timeout; the bridge waits indefinitely.
- DRAIN:
  - out_valid=1 and out_data = low W bits of the shift register.
  - On out_valid&out_ready the register shifts right by W and the out counter increments.
  - out_last=1 when ocnt=36; word 36 carries bits [1163:1152] in [11:0], with [31:12] zero.
  - out_data and out_last are held stable while out_ready=0.
  - After the last beat is accepted go to LOAD and assert core_reset=1 on that edge.
- core_reset timing:
  - core_reset is registered.
  - It is continuously high in LOAD and KICK, at least 2 cycles before release, which covers the core's internal delay chain.
  - It falls on the KICK→RUN edge.
- Simultaneous events:
  - in_valid during KICK, RUN or DRAIN is not accepted (in_ready=0).
  - core_done during DRAIN is ignored; the captured result is unaffected.
- Reset mid-operation, in any state:
  - Abandon the job.
  - Return to LOAD with counters cleared and operands zeroed.
  - out_valid drops immediately (asynchronously).
- busy = (state != LOAD).

Decomposition:
- Package pairing_bridge_pkg holds:
  - M, W, IN_WPO, IN_WORDS, OUT_WORDS, KICK_CYCLES=2;
  - a 2-bit state encoding LOAD=0, KICK=1, RUN=2, DRAIN=3.
- Sub-module result_serializer:
  - Parallel load of 12*M bits, W-bit shift-out with valid/ready and last.
  - Has its own async active-low reset.
- Operand loading and the FSM stay in the top level.

Test Plan:
- Basic load: after reset release send 28 words, with word k = 32'h1000_0000+k.
  - Required: core_x1[31:0]=32'h1000_0000 and core_y2[193:192]=2'b11 (word 27 = 32'h1000_001B, low two bits).
  - Required: core_reset is high through the cycle after beat 28, then low.
- Completion: a core model raises core_done with core_out = {12*M{1'b1}}, 5 cycles into RUN.
  - Required: 37 out beats; words 0..35 = 32'hFFFF_FFFF; word 36 = 32'h0000_0FFF with out_last=1.
  - Required: busy falls after the last beat.
- Backpressure: hold out_ready=0 for 10 cycles mid-drain, then random toggling.
  - Required: out_data stable while stalled; no word duplicated or skipped; total 37 beats.
- Input stalls and illegal input:
  - Drive in_valid with gaps; the operands must still assemble correctly.
  - Drive in_valid=1 during RUN; in_ready stays 0 and the operands are unchanged.
- Stale done: hold core_done=1 from the previous job until the model sees core_reset.
  - Required: the bridge ignores it in KICK and captures only on the next rising done in RUN.
- Reset mid-job: assert reset=0 for 1 cycle at DRAIN beat 10, between clock edges.
  - Required: out_valid=0 immediately; state LOAD; the next 28-word load starts from operand x1 word 0.
